// File: rtl/arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl.sv
// ---------------------------------------------------------------------------
// arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl
//
// Regional power-enable controller on the source side of the RCB clock-gating
// interface. It turns array-activity requests into RPEn and the LCP delay bits
// Fd/Rd. It also adds a wake latency, idle hysteresis and a ReqRdy handshake.
// Everything runs on the ungated grid clock.
//
// Ports:
//   CkGridX1N  in   ungated grid clock, rising edge
//   RstX1H     in   synchronous active-high reset
//   ReqVec     in   [NUM_REQ] activity requests (OR-reduced)
//   ForceOn    in   override request, same effect as any ReqVec bit
//   IdleCfg    in   [IDLE_W] idle cycles before RPEn drops
//   FdCfg      in   requested LCP Fd value
//   RdCfg      in   requested LCP Rd value
//   ClrCnt     in   clears WakeCnt, wins over a coincident increment
//   RPEn       out  regional power enable (registered)
//   Fd, Rd     out  LCP bits (registered, change only while RPEn is low)
//   ReqRdy     out  gated clock stable, requesters may proceed (registered)
//   WakeCnt    out  [CNT_W] saturating count of wake events
// ---------------------------------------------------------------------------
module arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned IDLE_W   = 6,
    parameter int unsigned WAKE_LAT = 2,
    parameter int unsigned CNT_W    = 16,
    parameter logic        FD_RST   = 1'b0,
    parameter logic        RD_RST   = 1'b0
) (
    input  logic               CkGridX1N,
    input  logic               RstX1H,
    input  logic [NUM_REQ-1:0] ReqVec,
    input  logic               ForceOn,
    input  logic [IDLE_W-1:0]  IdleCfg,
    input  logic               FdCfg,
    input  logic               RdCfg,
    input  logic               ClrCnt,
    output logic               RPEn,
    output logic               Fd,
    output logic               Rd,
    output logic               ReqRdy,
    output logic [CNT_W-1:0]   WakeCnt
);

    // One counter serves both the wake latency and the idle hysteresis, so it
    // is sized for whichever of the two needs more bits.
    localparam int unsigned WW = (WAKE_LAT > 0) ? $clog2(WAKE_LAT + 1) : 1;
    localparam int unsigned CW = (IDLE_W > WW) ? IDLE_W : WW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAKE,
        ST_ACTIVE,
        ST_HYST
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_rpen;
    logic              r_rdy;
    logic              r_fd;
    logic              r_rd;
    logic [CNT_W-1:0]  r_wake_cnt;

    logic w_req;
    logic w_wake_evt;

    assign w_req      = (|ReqVec) | ForceOn;
    assign w_wake_evt = (r_state == ST_IDLE) && w_req;

    always_ff @(posedge CkGridX1N) begin
        if (RstX1H) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rpen     <= 1'b0;
            r_rdy      <= 1'b0;
            r_fd       <= FD_RST;
            r_rd       <= RD_RST;
            r_wake_cnt <= '0;
        end else begin
            // LCP bits only move while the gated clock is off.
            if (r_state == ST_IDLE) begin
                r_fd <= FdCfg;
                r_rd <= RdCfg;
            end

            if (ClrCnt) begin
                r_wake_cnt <= '0;
            end else if (w_wake_evt && (r_wake_cnt != '1)) begin
                r_wake_cnt <= r_wake_cnt + CNT_W'(1);
            end

            // RPEn/ReqRdy are registered alongside the next state so they
            // always equal the state decode without any input-to-output path.
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_rpen <= 1'b1;
                        if (WAKE_LAT == 0) begin
                            r_state <= ST_ACTIVE;
                            r_rdy   <= 1'b1;
                        end else begin
                            r_state <= ST_WAKE;
                            r_cnt   <= CW'(WAKE_LAT);
                        end
                    end
                end
                ST_WAKE: begin
                    // A dropped request does not abort the wake.
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_ACTIVE;
                        r_rdy   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (!w_req) begin
                        if (IdleCfg == '0) begin
                            r_state <= ST_IDLE;
                            r_rpen  <= 1'b0;
                            r_rdy   <= 1'b0;
                        end else begin
                            r_state <= ST_HYST;
                            r_cnt   <= CW'(IdleCfg);
                        end
                    end
                end
                ST_HYST: begin
                    if (w_req) begin
                        r_state <= ST_ACTIVE;
                    end else if (r_cnt == CW'(1)) begin
                        r_state <= ST_IDLE;
                        r_rpen  <= 1'b0;
                        r_rdy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rpen  <= 1'b0;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign RPEn    = r_rpen;
    assign ReqRdy  = r_rdy;
    assign Fd      = r_fd;
    assign Rd      = r_rd;
    assign WakeCnt = r_wake_cnt;

endmodule

// File: tb/tb_arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl.
// The DUT runs with WAKE_LAT=2 and CNT_W=4 so that WakeCnt saturation can be
// reached quickly. A timing-level model follows the outputs every cycle, and
// hand-computed literal expectations pin the directed scenarios.
// ---------------------------------------------------------------------------
module tb_arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl;

    localparam int WL  = 2;
    localparam int SAT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_vec;
    logic       force_on;
    logic [5:0] idle_cfg;
    logic       fd_cfg, rd_cfg, clr_cnt;
    logic       rpen, fd, rd, rdy;
    logic [3:0] wake_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl #(
        .NUM_REQ (4),
        .IDLE_W  (6),
        .WAKE_LAT(WL),
        .CNT_W   (4),
        .FD_RST  (1'b0),
        .RD_RST  (1'b0)
    ) dut (
        .CkGridX1N(clk),
        .RstX1H   (rst),
        .ReqVec   (req_vec),
        .ForceOn  (force_on),
        .IdleCfg  (idle_cfg),
        .FdCfg    (fd_cfg),
        .RdCfg    (rd_cfg),
        .ClrCnt   (clr_cnt),
        .RPEn     (rpen),
        .Fd       (fd),
        .Rd       (rd),
        .ReqRdy   (rdy),
        .WakeCnt  (wake_cnt)
    );

    // Model: "on" means power enabled, "ready" means the wake delay elapsed,
    // idle_left counts down the hysteresis window (0 = not idling).
    bit m_valid = 0;
    bit m_on, m_ready, m_fd, m_rd;
    int m_wake_left, m_idle_left, m_wakes;

    always @(posedge clk) begin
        bit req;
        bit was_off;
        req     = (req_vec != 4'd0) || force_on;
        was_off = !m_on;
        if (rst) begin
            m_valid = 1; m_on = 0; m_ready = 0; m_fd = 0; m_rd = 0;
            m_wake_left = 0; m_idle_left = 0; m_wakes = 0;
        end else if (m_valid) begin
            if (was_off) begin
                m_fd = fd_cfg;
                m_rd = rd_cfg;
            end
            if (clr_cnt)
                m_wakes = 0;
            else if (was_off && req)
                m_wakes = (m_wakes + 1 > SAT) ? SAT : m_wakes + 1;

            if (was_off) begin
                if (req) begin
                    m_on = 1;
                    m_wake_left = WL;
                    m_ready = (WL == 0);
                end
            end else if (!m_ready) begin
                m_wake_left = m_wake_left - 1;
                if (m_wake_left == 0) m_ready = 1;
            end else if (req) begin
                m_idle_left = 0;
            end else if (m_idle_left == 0) begin
                if (idle_cfg == 0) begin
                    m_on = 0; m_ready = 0;
                end else begin
                    m_idle_left = idle_cfg;
                end
            end else begin
                m_idle_left = m_idle_left - 1;
                if (m_idle_left == 0) begin
                    m_on = 0; m_ready = 0;
                end
            end
        end
    end

    // Single per-cycle compare process, sampling away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            n_tests += 5;
            if (rpen !== m_on) begin
                n_fail++; $display("FAIL model_rpen t=%0t got=%b exp=%b", $time, rpen, m_on);
            end
            if (rdy !== m_ready) begin
                n_fail++; $display("FAIL model_reqrdy t=%0t got=%b exp=%b", $time, rdy, m_ready);
            end
            if (fd !== m_fd) begin
                n_fail++; $display("FAIL model_fd t=%0t got=%b exp=%b", $time, fd, m_fd);
            end
            if (rd !== m_rd) begin
                n_fail++; $display("FAIL model_rd t=%0t got=%b exp=%b", $time, rd, m_rd);
            end
            if (int'(wake_cnt) != m_wakes) begin
                n_fail++; $display("FAIL model_wakecnt t=%0t got=%0d exp=%0d", $time, wake_cnt, m_wakes);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    initial begin
        rst = 1; req_vec = '0; force_on = 0; idle_cfg = 6'd4;
        fd_cfg = 0; rd_cfg = 0; clr_cnt = 0;
        tick(2);
        rst = 0;
        chk("reset_rpen", rpen, 0);
        chk("reset_reqrdy", rdy, 0);
        chk("reset_wakecnt", wake_cnt, 0);
        chk("reset_fd", fd, 0);
        tick(3);

        // Wake: RPEn on the first Req edge, ReqRdy two edges later.
        req_vec = 4'b0001;
        tick(); chk("wake_rpen_e0", rpen, 1); chk("wake_rdy_e0", rdy, 0);
        tick(); chk("wake_rdy_e1", rdy, 0);
        tick(); chk("wake_rdy_e2", rdy, 1); chk("wake_cnt1", wake_cnt, 1);

        // Fd request while active must not reach the RCB.
        fd_cfg = 1; rd_cfg = 1;
        tick(2); chk("fd_hold_active", fd, 0); chk("rd_hold_active", rd, 0);

        // Idle with IdleCfg=4: on through 3 more edges, off at the 4th.
        req_vec = 4'b0000;
        tick(); chk("hyst_e0_rpen", rpen, 1);
        tick(3); chk("hyst_e3_rpen", rpen, 1); chk("hyst_e3_rdy", rdy, 1);
        tick(); chk("hyst_e4_rpen", rpen, 0); chk("hyst_e4_rdy", rdy, 0);
        chk("fd_still_old", fd, 0);
        tick(); chk("fd_first_idle", fd, 1); chk("rd_first_idle", rd, 1);

        // IdleCfg=0: drop on the very first idle sample.
        fd_cfg = 0; rd_cfg = 0;
        req_vec = 4'b0010;
        tick(3); chk("wake2_rdy", rdy, 1); chk("wake_cnt2", wake_cnt, 2);
        idle_cfg = 6'd0; req_vec = 4'b0000;
        tick(); chk("idle0_rpen", rpen, 0); chk("idle0_rdy", rdy, 0);

        // Re-request during hysteresis, then a later idle restarts the count.
        req_vec = 4'b0001;
        tick(3);
        idle_cfg = 6'd3; req_vec = 4'b0000;
        tick(2);
        req_vec = 4'b0100;
        tick(); chk("hyst_abort_rpen", rpen, 1); chk("hyst_abort_rdy", rdy, 1);
        req_vec = 4'b0000;
        tick();
        idle_cfg = 6'd1;   // sampled only on entry into hysteresis
        tick(2); chk("hyst_restart_e2", rpen, 1);
        tick(); chk("hyst_restart_e3", rpen, 0);

        // Back-to-back request: exactly one low cycle, then re-wake.
        fd_cfg = 1; force_on = 1;
        tick(); chk("b2b_rpen", rpen, 1); chk("wake_cnt4", wake_cnt, 4);
        chk("fd_on_wake_edge", fd, 1);
        tick();

        // Reset during WAKE with cnt=1.
        rst = 1;
        tick(); chk("rst_mid_rpen", rpen, 0); chk("rst_mid_rdy", rdy, 0);
        chk("rst_mid_cnt", wake_cnt, 0); chk("rst_mid_fd", fd, 0);
        rst = 0;
        tick(); chk("rewake_rpen", rpen, 1); chk("rewake_cnt", wake_cnt, 1);

        // Saturation: finish the current wake, then 17 more wake events.
        force_on = 0; idle_cfg = 6'd0; fd_cfg = 0;
        tick(3);
        for (int i = 0; i < 17; i++) begin
            req_vec = 4'b1000;
            tick();
            req_vec = 4'b0000;
            tick(3);
        end
        chk("wakecnt_sat", wake_cnt, 15);

        // ClrCnt coincident with a wake event wins.
        req_vec = 4'b0001; clr_cnt = 1;
        tick(); chk("clr_wins_cnt", wake_cnt, 0); chk("clr_wake_rpen", rpen, 1);
        clr_cnt = 0; req_vec = 4'b0000;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
